pwm_led_driver: RTL and testbench
=================================

// Module: pwm_led_driver
// PURPOSE
//  Output stage downstream of the I2C register slave. Consumes the packed
//  register file and drives two PWM pins plus an 8-bit LED bus.
//  PWM uses a programmable prescaler, a shared period counter and
//  double-buffered (shadow) duty/period registers. I2C writes therefore
//  never produce glitched or runt pulses mid-period.
// PARAMETERS
//  REGCOUNT   8   number of 8-bit registers in registers_packed; must be >= 6
//  CHANNELS   2   PWM channels; fixed at 2 by the register map
// PORTS
//  clock             in   1            design clock (divided system clock)
//  reset             in   1            synchronous, active-high reset
//  registers_packed  in   8*REGCOUNT   reg i = bits [8*i+7:8*i], from I2C slave
//  pwm_out           out  2            PWM pins; bit 0 = ch0, bit 1 = ch1
//  led               out  8            LED bus
//  period_tick       out  1            1-cycle pulse at each period boundary
// BEHAVIOUR
//  Register map:
//   - reg0 = LED value
//   - reg1 = CTRL: [0] en0, [1] en1, [2] inv0, [3] inv1, rest ignored
//   - reg2 = PRESCALE
//   - reg3 = TOP
//   - reg4 = DUTY0
//   - reg5 = DUTY1
//  Reset: every output is 0. Prescaler, counter and all shadows are 0.
//   load_pending is set to 1.
//  Prescaler:
//   - pcnt counts 0..PRESCALE, reading the live register.
//   - tick is asserted on the cycle pcnt==PRESCALE; pcnt wraps to 0.
//   - PRESCALE=0: tick every cycle.
//   - If PRESCALE is lowered below pcnt, pcnt wraps to 0 without a tick.
//  Period counter:
//   - cnt (8b) increments on tick.
//   - On a tick with cnt==top_sh: cnt<=0 and the boundary fires.
//   - top_sh=0: cnt stays at 0 and every tick is a boundary.
//  Boundary (also the first tick after reset, via load_pending):
//   - top_sh<=TOP, duty_sh[i]<=DUTYi; load_pending clears.
//   - period_tick pulses high the cycle after the boundary tick.
//  Compare, per channel i:
//   - raw = (cnt < duty_sh[i]).
//   - duty_sh=0 -> constantly low.
//   - duty_sh > top_sh -> constantly high (100%).
//   - High time = duty_sh ticks of a (top_sh+1)-tick period.
//  Output: pwm_out[i] <= en_i ? (raw ^ inv_i) : 0, registered.
//   - Latency: 1 cycle from the cnt change.
//   - en and inv are live, not shadowed. Disable forces the pin low on the
//     next cycle, even mid-period.
//  LED: led <= reg0 every cycle, 1-cycle latency, unshadowed.
//  Reset mid-operation: all state returns to reset values on the next edge.
//   The outputs are 0 in the cycle after reset is sampled.
//  A register changing on the same cycle as a boundary: the new value is
//   loaded, because shadows sample registers_packed at that edge.
// STRUCTURE
//  pwm_pkg:
//   - localparams REG_LED=0, REG_CTRL=1, REG_PRESC=2, REG_TOP=3,
//     REG_DUTY0=4, REG_DUTY1=5
//   - CTRL bit indices
//   - function get_reg(packed, idx)
//  Sub-module pwm_channel, instantiated twice: holds duty_sh and does the
//   compare, enable and invert logic plus the output register. Ports:
//   clock, reset, load, duty_in, cnt, top_sh, en, inv, pwm.
//  The top level keeps the prescaler, period counter, top_sh, load_pending,
//   the LED register and period_tick.
// TESTING
//  1. Reset held 3 cycles with random registers
//     -> pwm_out=0, led=0, period_tick=0 throughout.
//  2. PRESCALE=0, TOP=9, DUTY0=3, en0=1
//     -> pwm_out[0] high 3 / low 7 cycles, period 10.
//     -> period_tick every 10 cycles.
//  3. Change DUTY0 3->7 mid-period
//     -> current period keeps 3 high; the next period shows 7 high.
//     -> No runt pulse.
//  4. DUTY1=0 -> ch1 always low.
//     DUTY1=200 with TOP=9 -> ch1 always high.
//     inv1=1 -> the complement of each.
//  5. PRESCALE=3, TOP=0, DUTY0=1 -> pwm_out[0] constant high.
//     -> period_tick once per 4 cycles.
//  6. Clear en0 mid-high-pulse -> pwm_out[0]=0 next cycle.
//     Assert reset mid-period -> all outputs 0 next cycle.
//     After release, the first tick loads the shadows.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map constants and field helpers for the PWM/LED output stage
package pwm_pkg;

  localparam int MAP_REGS  = 6;

  localparam int REG_LED   = 0;
  localparam int REG_CTRL  = 1;
  localparam int REG_PRESC = 2;
  localparam int REG_TOP   = 3;
  localparam int REG_DUTY0 = 4;
  localparam int REG_DUTY1 = 5;

  localparam int CTRL_EN0  = 0;
  localparam int CTRL_EN1  = 1;
  localparam int CTRL_INV0 = 2;
  localparam int CTRL_INV1 = 3;

  function automatic logic [7:0] get_reg(input logic [8*MAP_REGS-1:0] regs, input int idx);
    return regs[8*idx +: 8];
  endfunction

endpackage

// File: rtl/pwm_led_driver_if.sv
// rtl/pwm_led_driver_if.sv - register-file input and pin outputs of the PWM/LED driver
interface pwm_led_driver_if #(parameter int REGCOUNT = 8);

  logic [8*REGCOUNT-1:0] registers_packed;
  logic [1:0]            pwm_out;
  logic [7:0]            led;
  logic                  period_tick;

  modport master (output registers_packed, input pwm_out, led, period_tick);
  modport slave  (input registers_packed, output pwm_out, led, period_tick);

endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: duty shadow, compare, enable/invert, output register
module pwm_channel (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] duty_in,
  input  logic [7:0] cnt,
  input  logic [7:0] top_sh,
  input  logic       en,
  input  logic       inv,
  output logic       pwm
);

  logic [7:0] duty_sh_q;
  logic       pwm_q;
  logic       pwm_d;
  logic       raw;

  // A duty beyond the period length means the compare never goes low.
  assign raw   = (duty_sh_q > top_sh) | (cnt < duty_sh_q);
  assign pwm_d = en ? (raw ^ inv) : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      duty_sh_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      if (load) duty_sh_q <= duty_in;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_led_driver.sv
// rtl/pwm_led_driver.sv - prescaler, shared period counter and shadow loading feeding two PWM channels plus LED bus
module pwm_led_driver
  import pwm_pkg::*;
#(
  parameter int REGCOUNT = 8
) (
  input  logic             clock,
  input  logic             reset,
  pwm_led_driver_if.slave  bus
);

  logic [8*MAP_REGS-1:0] map_regs;
  logic [7:0] led_reg, ctrl, presc, top;
  logic [7:0] duty [2];

  assign map_regs = bus.registers_packed[8*MAP_REGS-1:0];
  assign led_reg  = get_reg(map_regs, REG_LED);
  assign ctrl     = get_reg(map_regs, REG_CTRL);
  assign presc    = get_reg(map_regs, REG_PRESC);
  assign top      = get_reg(map_regs, REG_TOP);
  assign duty[0]  = get_reg(map_regs, REG_DUTY0);
  assign duty[1]  = get_reg(map_regs, REG_DUTY1);

  logic unused_hi;
  if (REGCOUNT > MAP_REGS) begin : g_hi
    assign unused_hi = ^bus.registers_packed[8*REGCOUNT-1:8*MAP_REGS];
  end else begin : g_nohi
    assign unused_hi = 1'b0;
  end
  logic unused_bits;
  assign unused_bits = ^{unused_hi, ctrl[7:4]};

  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] top_sh_q;
  logic [7:0] led_q;
  logic       load_pending_q;
  logic       period_tick_q;
  logic       tick, load;

  // pcnt above a freshly lowered PRESCALE wraps silently instead of ticking.
  assign tick = (pcnt_q == presc);
  assign load = tick & ((cnt_q == top_sh_q) | load_pending_q);

  always_comb begin
    pcnt_d = (pcnt_q >= presc) ? 8'd0 : pcnt_q + 8'd1;
    cnt_d  = cnt_q;
    if (load)      cnt_d = 8'd0;
    else if (tick) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q         <= 8'd0;
      cnt_q          <= 8'd0;
      top_sh_q       <= 8'd0;
      led_q          <= 8'd0;
      load_pending_q <= 1'b1;
      period_tick_q  <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      cnt_q         <= cnt_d;
      led_q         <= led_reg;
      period_tick_q <= load;
      if (load) begin
        top_sh_q       <= top;
        load_pending_q <= 1'b0;
      end
    end
  end

  logic [1:0] pwm_w;
  for (genvar i = 0; i < 2; i++) begin : g_ch
    pwm_channel u_ch (
      .clock   (clock),
      .reset   (reset),
      .load    (load),
      .duty_in (duty[i]),
      .cnt     (cnt_q),
      .top_sh  (top_sh_q),
      .en      (ctrl[CTRL_EN0 + i]),
      .inv     (ctrl[CTRL_INV0 + i]),
      .pwm     (pwm_w[i])
    );
  end

  assign bus.pwm_out     = pwm_w;
  assign bus.led         = led_q;
  assign bus.period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_led_driver.sv
// tb/tb_pwm_led_driver.sv - scoreboard bench for pwm_led_driver against a period-level reference model
module tb_pwm_led_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_led_driver_if #(.REGCOUNT(8)) bus ();
  pwm_led_driver #(.REGCOUNT(8)) dut (.clock(clk), .reset(rst), .bus(bus));

  typedef struct packed {
    logic [1:0] pwm;
    logic [7:0] led;
    logic       pt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] regs [8];

  int m_phase, m_pos, m_top, m_pend;
  int m_duty [2];

  function automatic logic [63:0] pack_regs();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[8*i +: 8] = regs[i];
    return p;
  endfunction

  function automatic bit level(input int pos, input int duty, input int top);
    if (duty == 0) return 1'b0;
    if (duty > top) return 1'b1;
    return pos < duty;
  endfunction

  task automatic model_edge();
    exp_t e;
    int presc;
    bit tk, bnd, lvl;
    e = '0;
    if (rst) begin
      m_phase = 0; m_pos = 0; m_top = 0; m_pend = 1;
      m_duty[0] = 0; m_duty[1] = 0;
    end else begin
      presc = int'(regs[2]);
      tk  = (m_phase == presc);
      bnd = tk && (m_pos == m_top || m_pend != 0);
      for (int ch = 0; ch < 2; ch++) begin
        lvl = level(m_pos, m_duty[ch], m_top) ^ regs[1][2+ch];
        e.pwm[ch] = regs[1][ch] ? lvl : 1'b0;
      end
      e.led = regs[0];
      e.pt  = bnd;
      m_phase = (m_phase >= presc) ? 0 : m_phase + 1;
      if (bnd) begin
        m_pos = 0; m_top = int'(regs[3]);
        m_duty[0] = int'(regs[4]); m_duty[1] = int'(regs[5]);
        m_pend = 0;
      end else if (tk) begin
        m_pos++;
      end
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({bus.pwm_out, bus.led, bus.period_tick} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got pwm=%b led=%h tick=%b want pwm=%b led=%h tick=%b",
                 $time, bus.pwm_out, bus.led, bus.period_tick, e.pwm, e.led, e.pt);
      end
    end
  end

  task automatic step();
    bus.registers_packed = pack_regs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic measure(input int n, output int hi0, output int hi1, output int tks);
    hi0 = 0; hi1 = 0; tks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi0 += int'(bus.pwm_out[0]);
      hi1 += int'(bus.pwm_out[1]);
      tks += int'(bus.period_tick);
    end
  endtask

  task automatic wait_tick(input string name);
    int k;
    k = 0;
    while (bus.period_tick !== 1'b1 && k < 300) begin step(); k++; end
    if (k >= 300) check_int(name, 0, 1);
  endtask

  task automatic set_pwm(input int ctrl, input int presc, input int top, input int d0, input int d1);
    regs[1] = 8'(ctrl); regs[2] = 8'(presc); regs[3] = 8'(top);
    regs[4] = 8'(d0);   regs[5] = 8'(d1);
  endtask

  initial begin
    int h0, h1, tk;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);

    // Reset held with churning registers.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      step();
      check_int("reset_outputs", int'({bus.pwm_out, bus.led, bus.period_tick}), 0);
    end
    rst = 1'b0;

    regs[0] = 8'hA5;
    set_pwm(1, 0, 9, 3, 0);
    run(25);
    measure(20, h0, h1, tk);
    check_int("duty3_high", h0, 6);
    check_int("top9_ticks", tk, 2);
    check_int("led_value", int'(bus.led), 'hA5);

    wait_tick("wait_mid_period");
    run(4);
    regs[4] = 8'd7;
    wait_tick("wait_after_duty_change");
    measure(10, h0, h1, tk);
    check_int("duty7_high", h0, 7);

    set_pwm(3, 0, 9, 7, 0);
    run(12);
    measure(10, h0, h1, tk);
    check_int("duty1_zero_low", h1, 0);
    regs[1] = 8'd11;
    run(2);
    measure(10, h0, h1, tk);
    check_int("duty1_zero_inv", h1, 10);
    set_pwm(3, 0, 9, 7, 200);
    run(12);
    measure(10, h0, h1, tk);
    check_int("duty1_full_high", h1, 10);
    regs[1] = 8'd11;
    run(2);
    measure(10, h0, h1, tk);
    check_int("duty1_full_inv", h1, 0);

    set_pwm(1, 3, 0, 1, 0);
    run(30);
    measure(8, h0, h1, tk);
    check_int("top0_const_high", h0, 8);
    check_int("presc3_ticks", tk, 2);

    set_pwm(1, 0, 9, 7, 0);
    run(25);
    wait_tick("wait_before_disable");
    run(2);
    check_int("pulse_high_before_disable", int'(bus.pwm_out[0]), 1);
    regs[1] = 8'd0;
    step();
    check_int("disable_next_cycle", int'(bus.pwm_out[0]), 0);
    regs[1] = 8'd1;
    run(3);
    rst = 1'b1;
    step();
    check_int("midrun_reset", int'({bus.pwm_out, bus.led, bus.period_tick}), 0);
    rst = 1'b0;
    step();
    check_int("first_tick_loads", int'(bus.period_tick), 1);
    run(20);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(5))
          0: regs[0] = 8'($urandom);
          1: regs[1] = 8'($urandom_range(15));
          2: regs[2] = 8'($urandom_range(3));
          3: regs[3] = 8'($urandom_range(15));
          4: regs[4] = 8'($urandom_range(20));
          default: regs[5] = 8'($urandom_range(20));
        endcase
      end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    step();
    @(negedge clk);
    #1;
    check_int("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
